// File: rtl/saturn_serial_tx.sv
// saturn_serial_tx
// Debug UART transmitter fed by the saturn_bus char stream. Chars are queued in a
// small FIFO and sent as 8N1 frames on o_tx, LSB first.
//
// Parameters
//   CLKS_PER_BIT  i_clk cycles per UART bit (>= 2)
//   FIFO_DEPTH    char FIFO entries (power of 2, >= 2)
//
// Ports
//   i_clk          system clock, posedge
//   i_reset_n      asynchronous active-low reset
//   i_char         char to queue
//   i_char_valid   i_char is meaningful
//   i_char_send    one-cycle push strobe
//   o_serial_busy  FIFO full, producer must hold off
//   o_tx           UART line, idle high
//   o_overflow     sticky, a push was dropped while full
//   o_fifo_count   FIFO occupancy
//
// Optional feature macro: SATURN_SERIAL_CRLF_EN
//   When defined, an LF at the FIFO head is preceded on the line by a CR.
//   The CR is generated from a pending_lf flag without popping, so the LF
//   still occupies one FIFO entry until it is itself sent.

module saturn_serial_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [7:0]                    i_char,
    input  logic                          i_char_valid,
    input  logic                          i_char_send,
    output logic                          o_serial_busy,
    output logic                          o_tx,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          busy_q,   busy_d;
    logic          ovf_q,    ovf_d;
    logic [1:0]    state_q,  state_d;
    logic [7:0]    shift_q,  shift_d;
    logic [BW-1:0] baud_q,   baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q,     tx_d;
`ifdef SATURN_SERIAL_CRLF_EN
    logic          pending_lf_q, pending_lf_d;
`endif

    logic       push_req;
    logic       full;
    logic       push;
    logic       pop;
    logic [7:0] head;

    // Full is judged on the registered count, so a pop in the same cycle
    // never makes room for a push.
    assign push_req = i_char_send & i_char_valid;
    assign full     = (count_q == DEPTH_C);
    assign push     = push_req & ~full;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        pop       = 1'b0;
`ifdef SATURN_SERIAL_CRLF_EN
        pending_lf_d = pending_lf_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (count_q != '0) begin
                    state_d = S_START;
`ifdef SATURN_SERIAL_CRLF_EN
                    // First visit to an LF head sends CR and leaves the LF queued;
                    // the second visit pops and sends the LF itself.
                    if (head == 8'h0A && !pending_lf_q) begin
                        shift_d      = 8'h0D;
                        pending_lf_d = 1'b1;
                    end else begin
                        shift_d      = head;
                        pop          = 1'b1;
                        pending_lf_d = 1'b0;
                    end
`else
                    shift_d = head;
                    pop     = 1'b1;
`endif
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
    end

    // Line level is registered from the current state, so it trails the FSM by
    // one cycle: a pop at edge N+1 shows as a falling line at edge N+2.
    always_comb begin
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        busy_d = (count_d == DEPTH_C);
        ovf_d  = ovf_q | (push_req & full);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_char;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= S_IDLE;
            shift_q   <= '0;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

`ifdef SATURN_SERIAL_CRLF_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending_lf_q <= 1'b0;
        end else begin
            pending_lf_q <= pending_lf_d;
        end
    end
`endif

    assign o_serial_busy = busy_q;
    assign o_tx          = tx_q;
    assign o_overflow    = ovf_q;
    assign o_fifo_count  = count_q;

endmodule

// File: tb/tb_saturn_serial_tx.sv
module tb_saturn_serial_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] ch;
    logic       valid;
    logic       send;
    logic       busy;
    logic       tx;
    logic       ovf;
    logic [2:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic       mon_en = 1'b1;
    logic [7:0] mon_q [$];

    saturn_serial_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_char        (ch),
        .i_char_valid  (valid),
        .i_char_send   (send),
        .o_serial_busy (busy),
        .o_tx          (tx),
        .o_overflow    (ovf),
        .o_fifo_count  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       send;
        logic       valid;
        logic [7:0] ch;
        logic [2:0] cnt;
        logic       busy;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int c;
        c = 0;
        while (mon_q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("wait_bytes", 32'(mon_q.size()), 32'(n));
    endtask

    task automatic push_one(input logic [7:0] v);
        @(negedge clk);
        send  = 1'b1;
        valid = 1'b1;
        ch    = v;
        @(posedge clk);
        #1;
        @(negedge clk);
        send  = 1'b0;
        valid = 1'b0;
    endtask

    // UART line monitor: samples mid-bit on falling clock edges.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                check("mon_start", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                check("mon_stop", 32'(tx), 32'd1);
                if (mon_en) mon_q.push_back(b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_tx [46];
        logic [7:0] v41;
        int idx;
        int cyc;

        // idle/push/overflow table, applied one row per clock
        vecs[0] = '{send: 1'b1, valid: 1'b0, ch: 8'hEE, cnt: 3'd0, busy: 1'b0, ovf: 1'b0};
        vecs[1] = '{send: 1'b0, valid: 1'b1, ch: 8'hEE, cnt: 3'd0, busy: 1'b0, ovf: 1'b0};
        vecs[2] = '{send: 1'b1, valid: 1'b1, ch: 8'h41, cnt: 3'd1, busy: 1'b0, ovf: 1'b0};
        vecs[3] = '{send: 1'b1, valid: 1'b1, ch: 8'h42, cnt: 3'd1, busy: 1'b0, ovf: 1'b0};
        vecs[4] = '{send: 1'b1, valid: 1'b1, ch: 8'h43, cnt: 3'd2, busy: 1'b0, ovf: 1'b0};
        vecs[5] = '{send: 1'b1, valid: 1'b1, ch: 8'h44, cnt: 3'd3, busy: 1'b0, ovf: 1'b0};
        vecs[6] = '{send: 1'b1, valid: 1'b1, ch: 8'h45, cnt: 3'd4, busy: 1'b1, ovf: 1'b0};
        vecs[7] = '{send: 1'b1, valid: 1'b1, ch: 8'h46, cnt: 3'd4, busy: 1'b1, ovf: 1'b1};
        vecs[8] = '{send: 1'b0, valid: 1'b0, ch: 8'h00, cnt: 3'd4, busy: 1'b1, ovf: 1'b1};

        rst_n = 1'b0;
        send  = 1'b0;
        valid = 1'b0;
        ch    = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx_during", 32'(tx), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);

        // single char 0x41: exact line waveform, k = cycles after push edge
        v41 = 8'h41;
        for (int k = 0; k < 46; k++) exp_tx[k] = 8'd1;
        for (int k = 2; k <= 5; k++) exp_tx[k] = 8'd0;
        for (int bi = 0; bi < 8; bi++)
            for (int j = 0; j < 4; j++) exp_tx[6 + bi * 4 + j] = {7'd0, v41[bi]};
        @(negedge clk);
        send  = 1'b1;
        valid = 1'b1;
        ch    = 8'h41;
        @(posedge clk);
        #1;
        check("single_cnt", 32'(cnt), 32'd1);
        @(negedge clk);
        send  = 1'b0;
        valid = 1'b0;
        for (int k = 1; k < 46; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("single_tx_k%0d", k), 32'(tx), 32'(exp_tx[k]));
        end
        wait_bytes(1, 100);
        if (mon_q.size() > 0) check("single_byte", 32'(mon_q.pop_front()), 32'h41);
        mon_q.delete();

        // table: ignored strobes, push run into a busy transmitter, overflow
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            send  = vecs[i].send;
            valid = vecs[i].valid;
            ch    = vecs[i].ch;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(vecs[i].cnt));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
        end
        @(negedge clk);
        send  = 1'b0;
        valid = 1'b0;
        wait_bytes(5, 400);
        for (int i = 0; i < 5; i++)
            if (mon_q.size() > 0) check($sformatf("tbl_byte%0d", i), 32'(mon_q.pop_front()), 32'(8'h41 + i));
        repeat (10) @(posedge clk);
        #1;
        check("tbl_drain_cnt", 32'(cnt), 32'd0);
        check("tbl_drain_busy", 32'(busy), 32'd0);
        check("tbl_ovf_sticky", 32'(ovf), 32'd1);
        mon_q.delete();

        // wrap: 10 chars gated by busy
        do_reset();
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 2000) begin
            @(negedge clk);
            if (!busy) begin
                send  = 1'b1;
                valid = 1'b1;
                ch    = 8'h30 + 8'(idx);
                idx++;
            end else begin
                send = 1'b0;
            end
            cyc++;
        end
        @(negedge clk);
        send  = 1'b0;
        valid = 1'b0;
        check("wrap_pushed", 32'(idx), 32'd10);
        wait_bytes(10, 1000);
        for (int i = 0; i < 10; i++)
            if (mon_q.size() > 0) check($sformatf("wrap_byte%0d", i), 32'(mon_q.pop_front()), 32'(8'h30 + i));
        check("wrap_ovf", 32'(ovf), 32'd0);
        repeat (10) @(posedge clk);
        mon_q.delete();

        // async reset while a data bit is low
        mon_en = 1'b0;
        @(negedge clk);
        send  = 1'b1;
        valid = 1'b1;
        ch    = 8'h55;
        @(posedge clk);
        #1;
        @(negedge clk);
        send  = 1'b0;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("amid_tx_low", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("amid_tx_async", 32'(tx), 32'd1);
        check("amid_cnt", 32'(cnt), 32'd0);
        check("amid_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            check("amid_no_frame", 32'(tx), 32'd1);
        end
        check("amid_cnt_after", 32'(cnt), 32'd0);
        mon_en = 1'b1;

        // LF handling
        push_one(8'h0A);
        repeat (8) @(posedge clk);
        #1;
`ifdef SATURN_SERIAL_CRLF_EN
        check("lf_cnt_during_cr", 32'(cnt), 32'd1);
        wait_bytes(2, 200);
        if (mon_q.size() > 0) check("lf_byte0", 32'(mon_q.pop_front()), 32'h0D);
        if (mon_q.size() > 0) check("lf_byte1", 32'(mon_q.pop_front()), 32'h0A);
`else
        check("lf_cnt_during", 32'(cnt), 32'd0);
        wait_bytes(1, 200);
        if (mon_q.size() > 0) check("lf_byte0", 32'(mon_q.pop_front()), 32'h0A);
`endif
        repeat (60) @(posedge clk);
        check("lf_no_extra", 32'(mon_q.size()), 32'd0);
        check("lf_cnt_end", 32'(cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
